// File: rtl/alu_srcb_pkg.sv
// Shared types and helpers for the ALU operand-B selector.
package alu_srcb_pkg;

    // Immediate extension modes.
    typedef enum logic [1:0] {
        EXT_SIGN     = 2'd0,
        EXT_ZERO     = 2'd1,
        EXT_SIGN_SL2 = 2'd2,
        EXT_UPPER    = 2'd3
    } ext_mode_t;

    // Widest operand the extension helper can produce.
    localparam int EXT_MAX_W = 64;

    // Extend an imm_w-bit immediate to width bits (both <= EXT_MAX_W).
    // The result is returned right-aligned in EXT_MAX_W bits, with bits at and
    // above width cleared; callers keep the low width bits.
    function automatic logic [EXT_MAX_W-1:0] extend_imm(
        input logic [EXT_MAX_W-1:0] imm,
        input ext_mode_t            mode,
        input int                   imm_w,
        input int                   width
    );
        logic        [EXT_MAX_W-1:0] lo_mask;
        logic        [EXT_MAX_W-1:0] w_mask;
        logic        [EXT_MAX_W-1:0] imm_z;
        logic signed [EXT_MAX_W-1:0] imm_sx;
        logic        [EXT_MAX_W-1:0] res;
        lo_mask = (64'd1 << imm_w) - 64'd1;
        w_mask  = (width >= EXT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        imm_z   = imm & lo_mask;
        // Park the immediate at the top, then arithmetic-shift back down.
        imm_sx  = $signed(imm_z << (EXT_MAX_W - imm_w)) >>> (EXT_MAX_W - imm_w);
        case (mode)
            EXT_SIGN:     res = $unsigned(imm_sx);
            EXT_ZERO:     res = imm_z;
            EXT_SIGN_SL2: res = $unsigned(imm_sx <<< 2);
            EXT_UPPER:    res = imm_z << (width - imm_w);
            default:      res = '0;
        endcase
        return res & w_mask;
    endfunction

endpackage

// File: rtl/alu_srcb_sel_pipe_skid.sv
// Two-register valid/ready skid buffer: R drives the output, S catches the
// one operand that arrives while R is stalled. in_ready is pure state.
module srcb_skid_buffer
    import alu_srcb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_data_p1;
    logic             r_vld_p1;
    logic [WIDTH-1:0] s_data_p1;
    logic             s_vld_p1;
    logic             accept;
    logic             consume;

    assign accept    = in_valid && in_ready;
    assign consume   = r_vld_p1 && out_ready;
    assign in_ready  = !s_vld_p1;
    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;

    // Move operands through R and S; S only fills when R is stalled, and an
    // accept never coincides with a full S because in_ready is then low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
            s_data_p1 <= '0;
            s_vld_p1  <= 1'b0;
        end else if (accept && (!r_vld_p1 || consume)) begin
            r_data_p1 <= in_data;
            r_vld_p1  <= 1'b1;
        end else if (accept) begin
            s_data_p1 <= in_data;
            s_vld_p1  <= 1'b1;
        end else if (consume && s_vld_p1) begin
            r_data_p1 <= s_data_p1;
            s_vld_p1  <= 1'b0;
        end else if (consume) begin
            r_vld_p1  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_srcb_sel_pipe.sv
// Registered ALU operand-B selector: channel / extended immediate / constant
// increment, behind a skid-buffered valid/ready output, with a sticky flag
// for illegal select codes.
module alu_srcb_sel_pipe
    import alu_srcb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 4,
    parameter int IMM_W     = 16,
    parameter int SEL_W     = 4,
    parameter int CONST_INC = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [1:0]              ext_mode,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [IMM_W-1:0]        imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    sel_err,
    input  logic                    clear_err
);

    localparam int SEL_IMM = NUM_IN;
    localparam int SEL_INC = NUM_IN + 1;

    logic [WIDTH-1:0] ext_val_p0;
    logic [WIDTH-1:0] operand_p0;
    logic             sel_legal_p0;
    logic             accept;

    assign accept = in_valid && in_ready;

    // Extend the raw immediate according to the requested mode.
    always_comb begin
        ext_val_p0 = WIDTH'(extend_imm(EXT_MAX_W'(imm), ext_mode_t'(ext_mode),
                                       IMM_W, WIDTH));
    end

    // Decode the select into an operand; unknown codes give 0 and are illegal.
    always_comb begin
        operand_p0   = '0;
        sel_legal_p0 = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                operand_p0   = data_in[k*WIDTH +: WIDTH];
                sel_legal_p0 = 1'b1;
            end
        end
        if (sel == SEL_W'(SEL_IMM)) begin
            operand_p0   = ext_val_p0;
            sel_legal_p0 = 1'b1;
        end else if (sel == SEL_W'(SEL_INC)) begin
            operand_p0   = WIDTH'(CONST_INC);
            sel_legal_p0 = 1'b1;
        end
    end

    // Sticky illegal-select flag; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (accept && !sel_legal_p0) begin
            sel_err <= 1'b1;
        end else if (clear_err) begin
            sel_err <= 1'b0;
        end
    end

    // ---- stage boundary: selected operand registered into the skid buffer
    srcb_skid_buffer #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (operand_p0),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_alu_srcb_sel_pipe.sv
// Directed bench for alu_srcb_sel_pipe with a queue-based reference model.
module tb_alu_srcb_sel_pipe;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   sel;
    logic [1:0]   ext_mode;
    logic [127:0] data_in;
    logic [15:0]  imm;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         sel_err;
    logic         clear_err;

    logic [31:0]  ch0, ch1, ch2, ch3;
    assign data_in = {ch3, ch2, ch1, ch0};

    int checks = 0;
    int errs   = 0;

    logic [31:0] q[$];
    logic        err_m = 1'b0;

    alu_srcb_sel_pipe dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .ext_mode (ext_mode),
        .data_in  (data_in),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sel_err  (sel_err),
        .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand the selector must produce, straight from the selection rules.
    function automatic logic [31:0] model_op(input logic [3:0] s, input logic [1:0] m,
                                             input logic [15:0] im, input logic [127:0] d);
        logic signed [31:0] sx;
        int idx;
        sx  = $signed(im);
        idx = s;
        if (idx < 4) return d[idx*32 +: 32];
        if (idx == 5) return 32'd4;
        if (idx > 5) return 32'd0;
        case (m)
            2'd0:    return sx;
            2'd1:    return {16'h0000, im};
            2'd2:    return sx * 4;
            default: return {im, 16'h0000};
        endcase
    endfunction

    // Reference bookkeeping on each handshake.
    always @(posedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model_op(sel, ext_mode, imm, data_in));
            if (in_valid && in_ready && sel > 4'd5) err_m = 1'b1;
            else if (clear_err) err_m = 1'b0;
        end
    end

    always @(negedge reset_n) begin
        q.delete();
        err_m = 1'b0;
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        check("model_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        check("model_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        check("model_sel_err", {31'd0, sel_err}, {31'd0, err_m});
        if (q.size() > 0) check("model_out_data", out_data, q[0]);
    end

    task automatic drive(input logic [3:0] s, input logic [1:0] m, input logic [15:0] im,
                         input logic v);
        sel      = s;
        ext_mode = m;
        imm      = im;
        in_valid = v;
    endtask

    logic [31:0] exp_ext [4] = '{32'hFFFF_FFFC, 32'h0000_FFFC, 32'hFFFF_FFF0, 32'hFFFC_0000};

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        sel       = '0;
        ext_mode  = '0;
        imm       = '0;
        out_ready = 1'b0;
        clear_err = 1'b0;
        ch0 = 32'h1111_1111;
        ch1 = 32'h2222_2222;
        ch2 = 32'hDEAD_BEEF;
        ch3 = 32'h3333_3333;
        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_data", out_data, 32'd0);
        check("reset_sel_err", {31'd0, sel_err}, 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Channel select.
        drive(4'd2, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("ch2_data", out_data, 32'hDEAD_BEEF);
        check("ch2_valid", {31'd0, out_valid}, 32'd1);
        check("ch2_in_ready", {31'd0, in_ready}, 32'd1);

        // Immediate extension modes, back to back.
        for (int m = 0; m < 4; m++) begin
            drive(4'd4, 2'(m), 16'hFFFC, 1'b1);
            @(negedge clk);
            check("ext_mode", out_data, exp_ext[m]);
        end
        drive(4'd5, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("inc_data", out_data, 32'h0000_0004);
        @(negedge clk);

        // Back-pressure: A, B, C with the consumer stalled.
        out_ready = 1'b0;
        drive(4'd0, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        check("bp_a_held", out_data, 32'h1111_1111);
        check("bp_ready_1", {31'd0, in_ready}, 32'd1);
        drive(4'd1, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        check("bp_ready_0", {31'd0, in_ready}, 32'd0);
        check("bp_a_still", out_data, 32'h1111_1111);
        drive(4'd3, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        check("bp_c_held_off", {31'd0, in_ready}, 32'd0);
        check("bp_a_stable", out_data, 32'h1111_1111);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b_out", out_data, 32'h2222_2222);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_c_out", out_data, 32'h3333_3333);
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Illegal select and sticky error.
        drive(4'hF, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("illegal_data", out_data, 32'd0);
        check("illegal_err", {31'd0, sel_err}, 32'd1);
        drive(4'd5, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("err_sticky", {31'd0, sel_err}, 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("err_cleared", {31'd0, sel_err}, 32'd0);
        drive(4'hF, 2'd0, 16'h0, 1'b0);
        @(negedge clk);
        check("err_no_accept", {31'd0, sel_err}, 32'd0);
        drive(4'hF, 2'd0, 16'h0, 1'b1);
        clear_err = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        clear_err = 1'b0;
        check("err_set_wins", {31'd0, sel_err}, 32'd1);
        @(negedge clk);

        // Asynchronous reset with R and S both full.
        out_ready = 1'b0;
        drive(4'd2, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        drive(4'd0, 2'd0, 16'h0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_full", {31'd0, in_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready}, 32'd1);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_err", {31'd0, sel_err}, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_srcb_sel_pipe.md
Name: alu_srcb_sel_pipe

Overview:
- Parametrised, registered successor to the multicycle datapath's ALU operand-B selector.
- Selects among NUM_IN register/data channels, an extended 16-bit immediate (four extension modes), or a constant increment.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so a stalled ALU stage never drops an operand.
- Flags illegal select codes with a sticky error bit.

Parameters:
- WIDTH, 32, operand width in bits; must be at least IMM_W+2.
- NUM_IN, 4, number of full-width data channels (1..8).
- IMM_W, 16, immediate width.
- SEL_W, 4, select width; must satisfy 2^SEL_W >= NUM_IN+2.
- CONST_INC, 4, constant driven for the increment select.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operand request valid
- in_ready  out  1  block can accept a request this cycle
- sel  in  SEL_W  source select
- ext_mode  in  2  immediate extension mode (package enum)
- data_in  in  NUM_IN*WIDTH  flattened channels; channel k is bits [k*WIDTH +: WIDTH]
- imm  in  IMM_W  raw immediate
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  selected operand
- sel_err  out  1  sticky illegal-select flag
- clear_err  in  1  synchronous clear of sel_err

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, skid empty, in_ready=1, sel_err=0.
- Select decode is combinational:
  - sel < NUM_IN: data_in channel sel.
  - sel == NUM_IN: extended immediate.
  - sel == NUM_IN+1: CONST_INC zero-extended to WIDTH.
  - Any other code is illegal: the operand is 0, and sel_err sets when the request is accepted.
- Extension modes, computed at WIDTH:
  - EXT_SIGN: sign-extend imm.
  - EXT_ZERO: zero-extend imm.
  - EXT_SIGN_SL2: sign-extend imm, then shift left 2; upper bits are discarded modulo 2^WIDTH.
  - EXT_UPPER: imm placed in bits [WIDTH-1:WIDTH-IMM_W], low bits 0.
- Handshakes:
  - A transfer occurs on a rising edge where valid && ready.
  - Accept: in_valid && in_ready.
  - Consume: out_valid && out_ready.
- Storage: output register R (drives out_data/out_valid) and skid register S.
- in_ready = !S_full. It is registered state, never combinationally dependent on out_ready.
- Latency: an accepted request appears on out_data exactly 1 cycle after acceptance when R is empty or being consumed that cycle.
- Per-edge rules, mutually exclusive and evaluated in order:
  - Accept, and (R empty or consume): R <= new operand. If S was full, R <= S and S <= new instead, to preserve order. S can only be full when in_ready=0, so this case cannot arise with an accept.
  - Accept, R full, no consume: S <= new; S_full=1; in_ready drops next cycle.
  - No accept, consume, S full: R <= S; S empty.
  - No accept, consume, S empty: out_valid <= 0.
- Ordering: operands leave in acceptance order, with no duplication or loss.
- While out_valid=1 and out_ready=0, out_data holds stable.
- Inputs (sel, ext_mode, imm, data_in) are sampled only at the accept edge; later changes have no effect on stored operands.
- sel_err:
  - Sets on an accepted illegal sel.
  - Cleared by clear_err.
  - Set wins over clear in the same cycle.
  - Not set by an illegal sel presented without acceptance.
- Reset mid-operation discards both R and S immediately; there is no partial output.

Decomposition:
- Package alu_srcb_pkg:
  - ext_mode_t enum: EXT_SIGN=0, EXT_ZERO=1, EXT_SIGN_SL2=2, EXT_UPPER=3.
  - function extend_imm(imm, mode) parametrised by widths.
  - Localparams SEL_IMM=NUM_IN and SEL_INC=NUM_IN+1, derived in the module.
- One sub-module, srcb_skid_buffer (WIDTH): two-register valid/ready skid, reused by other pipelined datapath stages. The top module holds select/extend logic and sel_err.

Test Plan:
- Reset, then sel=2, data_in ch2=32'hDEAD_BEEF, in_valid=1, out_ready=1 -> out_data=32'hDEAD_BEEF, out_valid=1 one cycle after accept; in_ready stays 1.
- sel=4 (SEL_IMM), imm=16'hFFFC, each ext_mode in turn -> outputs:
  - EXT_SIGN: 32'hFFFF_FFFC
  - EXT_ZERO: 32'h0000_FFFC
  - EXT_SIGN_SL2: 32'hFFFF_FFF0
  - EXT_UPPER: 32'hFFFC_0000
- sel=5 (SEL_INC) -> out_data=32'h0000_0004.
- Back-pressure: out_ready=0, issue 3 back-to-back requests A,B,C -> A held on out_data, B in skid, in_ready=0 after the 2nd accept, C held off. Raise out_ready -> outputs A, B, C in order, no loss or duplication.
- Illegal sel=4'hF with accept -> out_data=0, sel_err=1 next cycle. sel_err remains 1 across legal traffic. clear_err pulse -> 0. Simultaneous illegal accept + clear_err -> sel_err=1.
- Assert reset_n low asynchronously (between clock edges) while R and S are both full -> out_valid=0, in_ready=1 immediately, no stale operand after release.
